// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/MEM unified memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } arb_grant_t;

endpackage

// File: rtl/mem_arb_wait_counter.sv
// Free-running 32-bit cycle counter that advances while en is high and wraps.
module mem_arb_wait_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes IF fetches and MEM loads/stores onto one multi-cycle memory port.
// Define MEM_ARB_PERF_EN to add the per-side stall cycle counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_stall,

    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       if_wait_cnt,
    output logic [31:0]       d_wait_cnt
`endif
);

    arb_state_t        state;
    arb_grant_t        grant;
    logic [DATA_W-1:0] resp;

    // mem_we/addr/wdata are the payload registers themselves, so they cannot move mid-transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= GNT_IF;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            resp      <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    // Data wins ties: it belongs to the older instruction in the pipeline.
                    if (d_req) begin
                        grant     <= GNT_D;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_valid <= 1'b1;
                        state     <= REQ;
                    end else if (if_req) begin
                        grant     <= GNT_IF;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_valid <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        resp  <= mem_rdata;
                        state <= ACK;
                        if (grant == GNT_D) begin
                            d_ack <= 1'b1;
                        end else begin
                            if_ack <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata = resp;
    assign d_rdata  = resp;
    assign if_stall = if_req & ~if_ack;
    assign d_stall  = d_req & ~d_ack;

`ifdef MEM_ARB_PERF_EN
    mem_arb_wait_counter u_if_wait (
        .clk   (clk),
        .reset (reset),
        .en    (if_stall),
        .count (if_wait_cnt)
    );

    mem_arb_wait_counter u_d_wait (
        .clk   (clk),
        .reset (reset),
        .en    (d_stall),
        .count (d_wait_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a delay-programmable memory model.
// Also checks the stall counters when built with MEM_ARB_PERF_EN.
module tb_mem_port_arbiter;

    localparam logic [31:0] WR_TOKEN = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_ack, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ack, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_valid, mem_we, mem_ready, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] if_wait_cnt, d_wait_cnt;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_rdata       (if_rdata),
        .if_ack         (if_ack),
        .if_stall       (if_stall),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_rdata        (d_rdata),
        .d_ack          (d_ack),
        .d_stall        (d_stall),
        .mem_valid      (mem_valid),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ready      (mem_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .if_wait_cnt    (if_wait_cnt),
        .d_wait_cnt     (d_wait_cnt)
`endif
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        compared++;
        if (got !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, expv);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_wd;
    } mem_exp_t;

    typedef struct {
        bit          side_d;
        logic [31:0] rdata;
    } ack_exp_t;

    mem_exp_t    mem_q[$];
    ack_exp_t    ack_q[$];
    logic [31:0] shadow [0:1023];

    int          ready_delay = 0;
    int          resp_delay  = 0;
    int          req_wait    = 0;
    int          resp_wait   = 0;
    bit          pending     = 1'b0;
    logic [31:0] resp_data   = '0;

    // Memory model: decides ready/resp for the coming edge and checks the request payload.
    always @(negedge clk) begin
        mem_ready      = 1'b0;
        mem_resp_valid = 1'b0;
        if (reset) begin
            pending  = 1'b0;
            req_wait = 0;
        end else if (pending) begin
            checkOutput("mem_valid_in_wait", {31'b0, mem_valid}, 32'd0);
            if (resp_wait == resp_delay) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = resp_data;
                pending        = 1'b0;
            end else begin
                resp_wait++;
            end
        end else if (mem_valid) begin
            if (mem_q.size() == 0) begin
                checkOutput("mem_unexpected", {31'b0, mem_valid}, 32'd0);
            end else begin
                checkOutput("mem_we", {31'b0, mem_we}, {31'b0, mem_q[0].we});
                checkOutput("mem_addr", mem_addr, mem_q[0].addr);
                if (mem_q[0].chk_wd) checkOutput("mem_wdata", mem_wdata, mem_q[0].wdata);
                if (req_wait == ready_delay) begin
                    mem_ready = 1'b1;
                    pending   = 1'b1;
                    resp_wait = 0;
                    req_wait  = 0;
                    if (mem_we) begin
                        shadow[mem_addr[11:2]] = mem_wdata;
                        resp_data = WR_TOKEN ^ mem_wdata;
                    end else begin
                        resp_data = shadow[mem_addr[11:2]];
                    end
                    void'(mem_q.pop_front());
                end else begin
                    req_wait++;
                end
            end
        end
    end

    task automatic applyStimulus(input string name,
                                 input bit use_if, input logic [31:0] ia,
                                 input bit use_d, input bit we, input logic [31:0] da, input logic [31:0] wd,
                                 input int rdy, input int rsp,
                                 input int lat_first, input int lat_second,
                                 input int exp_if_wait, input int exp_d_wait);
        int       cycles;
        bit       if_done, d_done, first;
        mem_exp_t me;
        ack_exp_t ae;
`ifdef MEM_ARB_PERF_EN
        logic [31:0] if_cnt0 = if_wait_cnt;
        logic [31:0] d_cnt0  = d_wait_cnt;
`endif
        ready_delay = rdy;
        resp_delay  = rsp;
        if (use_d) begin
            me.we = we; me.addr = da; me.wdata = wd; me.chk_wd = we;
            mem_q.push_back(me);
            ae.side_d = 1'b1;
            ae.rdata  = we ? (WR_TOKEN ^ wd) : shadow[da[11:2]];
            ack_q.push_back(ae);
        end
        if (use_if) begin
            me.we = 1'b0; me.addr = ia; me.wdata = '0; me.chk_wd = 1'b0;
            mem_q.push_back(me);
            ae.side_d = 1'b0;
            ae.rdata  = shadow[ia[11:2]];
            ack_q.push_back(ae);
        end
        if_req = use_if; if_addr = ia;
        d_req = use_d; d_we = we; d_addr = da; d_wdata = wd;
        if_done = !use_if;
        d_done  = !use_d;
        first   = 1'b1;
        cycles  = 0;
        while (!(if_done && d_done) && cycles < 60) begin
            @(posedge clk); #1;
            cycles++;
            // After the grant edge the inputs are scrambled; the issued payload must not follow them.
            if (cycles == 1) begin
                if (use_d) begin
                    d_addr = $urandom; d_wdata = $urandom; d_we = ~we;
                end else if (use_if) begin
                    if_addr = $urandom;
                end
            end
            if (d_ack || if_ack) begin
                checkOutput({name, ":ack_excl"}, {31'b0, d_ack & if_ack}, 32'd0);
                if (ack_q.size() == 0) begin
                    checkOutput({name, ":ack_unexpected"}, 32'd1, 32'd0);
                end else begin
                    ae = ack_q.pop_front();
                    checkOutput({name, ":ack_side"}, {31'b0, d_ack}, {31'b0, ae.side_d});
                    checkOutput({name, ":rdata"}, ae.side_d ? d_rdata : if_rdata, ae.rdata);
                    checkOutput({name, ":latency"}, cycles, first ? lat_first : lat_second);
                    first = 1'b0;
                    if (ae.side_d) begin
                        checkOutput({name, ":d_stall_ack"}, {31'b0, d_stall}, 32'd0);
                        d_req  = 1'b0;
                        d_done = 1'b1;
                    end else begin
                        checkOutput({name, ":if_stall_ack"}, {31'b0, if_stall}, 32'd0);
                        if_req  = 1'b0;
                        if_done = 1'b1;
                    end
                end
            end else begin
                if (!d_done)  checkOutput({name, ":d_stall"}, {31'b0, d_stall}, 32'd1);
                if (!if_done) checkOutput({name, ":if_stall"}, {31'b0, if_stall}, 32'd1);
            end
        end
        if (!(if_done && d_done)) checkOutput({name, ":timeout"}, 32'd0, 32'd1);
`ifdef MEM_ARB_PERF_EN
        checkOutput({name, ":if_wait_cnt"}, if_wait_cnt - if_cnt0, exp_if_wait);
        checkOutput({name, ":d_wait_cnt"}, d_wait_cnt - d_cnt0, exp_d_wait);
`else
        if (exp_if_wait < 0 || exp_d_wait < 0) $display("[TB] note: negative wait expectation in %s", name);
`endif
        if_req = 1'b0;
        d_req  = 1'b0;
        @(posedge clk); #1;
        checkOutput({name, ":ack_pulse_end"}, {30'b0, d_ack, if_ack}, 32'd0);
        checkOutput({name, ":idle_mem_valid"}, {31'b0, mem_valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] ra, rw;
        int          rr, rs;
        for (int i = 0; i < 1024; i++) shadow[i] = 32'h1000_0000 + i;
        shadow[32'h10 >> 2]  = 32'hDEAD_BEEF;
        shadow[32'h200 >> 2] = 32'hCAFE_0200;

        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst:mem_valid", {31'b0, mem_valid}, 32'd0);
        checkOutput("rst:mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst:mem_addr", mem_addr, 32'd0);
        checkOutput("rst:mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst:acks", {30'b0, d_ack, if_ack}, 32'd0);
        checkOutput("rst:if_rdata", if_rdata, 32'd0);
        checkOutput("rst:d_rdata", d_rdata, 32'd0);
`ifdef MEM_ARB_PERF_EN
        checkOutput("rst:if_wait_cnt", if_wait_cnt, 32'd0);
        checkOutput("rst:d_wait_cnt", d_wait_cnt, 32'd0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle:mem_valid", {31'b0, mem_valid}, 32'd0);

        applyStimulus("fetch", 1, 32'h10, 0, 0, 0, 0, 0, 0, 3, 0, 3, 0);
        applyStimulus("collide", 1, 32'h14, 1, 0, 32'h200, 0, 0, 0, 3, 7, 7, 3);
        applyStimulus("store", 0, 0, 1, 1, 32'h40, 32'h1234, 3, 0, 6, 0, 0, 6);
        applyStimulus("load_back", 0, 0, 1, 0, 32'h40, 0, 0, 0, 3, 0, 0, 3);
        applyStimulus("backpress", 0, 0, 1, 0, 32'h200, 0, 5, 2, 10, 0, 0, 10);
        applyStimulus("fetch_slow", 1, 32'h10, 0, 0, 0, 0, 1, 4, 8, 0, 8, 0);

        // Reset lands while the transaction waits for its response; it must be dropped silently.
        ready_delay = 0;
        resp_delay  = 20;
        me_push(32'h80);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        @(posedge clk); #1;
        checkOutput("rstmid:mem_valid_req", {31'b0, mem_valid}, 32'd1);
        @(posedge clk); #1;
        checkOutput("rstmid:mem_valid_wait", {31'b0, mem_valid}, 32'd0);
        reset = 1'b1;
        d_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rstmid:mem_valid", {31'b0, mem_valid}, 32'd0);
        checkOutput("rstmid:acks", {30'b0, d_ack, if_ack}, 32'd0);
        checkOutput("rstmid:mem_we", {31'b0, mem_we}, 32'd0);
`ifdef MEM_ARB_PERF_EN
        checkOutput("rstmid:d_wait_cnt", d_wait_cnt, 32'd0);
`endif
        repeat (4) begin
            @(posedge clk); #1;
            checkOutput("rstmid:no_ack", {30'b0, d_ack, if_ack}, 32'd0);
        end
        applyStimulus("after_rst", 1, 32'h10, 0, 0, 0, 0, 0, 0, 3, 0, 3, 0);

        for (int k = 0; k < 4; k++) begin
            ra = $urandom_range(0, 1023) << 2;
            rw = $urandom;
            rr = $urandom_range(0, 3);
            rs = $urandom_range(0, 3);
            applyStimulus("rnd_store", 0, 0, 1, 1, ra, rw, rr, rs, 3 + rr + rs, 0, 0, 3 + rr + rs);
            applyStimulus("rnd_load", 0, 0, 1, 0, ra, 0, rs, rr, 3 + rr + rs, 0, 0, 3 + rr + rs);
        end

        checkOutput("queues_drained", mem_q.size() + ack_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    task automatic me_push(input logic [31:0] a);
        mem_exp_t me;
        me.we = 1'b0; me.addr = a; me.wdata = '0; me.chk_wd = 1'b0;
        mem_q.push_back(me);
    endtask

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one multi-cycle unified memory port between the pipeline's instruction-fetch (IF) stage and data-access (MEM) stage.
- Accepts one request per side and serializes them onto the memory port, one outstanding transaction at a time.
- Returns read data with a one-cycle ack pulse; exports per-side stall signals that drive PC/IF_ID write-enable and pipeline freeze.
- Sits between the CPU core and the memory model, replacing the separate InstMemory/DataMemory paths.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held until if_ack
if_addr  input  ADDR_W  fetch address
if_rdata  output  DATA_W  fetch data; valid while if_ack=1
if_ack  output  1  one-cycle completion pulse for fetch
if_stall  output  1  if_req & ~if_ack
d_req  input  1  data request; held until d_ack
d_we  input  1  1=store, 0=load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_rdata  output  DATA_W  load data; valid while d_ack=1
d_ack  output  1  one-cycle completion pulse for data
d_stall  output  1  d_req & ~d_ack
mem_valid  output  1  request to memory
mem_we  output  1  write enable to memory
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_ready  input  1  memory accepts request this cycle
mem_resp_valid  input  1  memory completion (read data valid, or write done)
mem_rdata  input  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, REQ, WAIT, ACK.
- IDLE:
  - If d_req=1: grant data; latch d_we/d_addr/d_wdata; go to REQ.
  - Else if if_req=1: grant fetch; latch if_addr, we=0; go to REQ.
  - Else stay in IDLE.
  - Data has fixed priority because it belongs to the older instruction.
- REQ:
  - mem_valid=1; mem_we/addr/wdata come from the latched payload and stay stable.
  - Go to WAIT in the cycle mem_ready=1; otherwise stay.
- WAIT:
  - mem_valid=0.
  - On mem_resp_valid=1: latch mem_rdata into the response register (latched for writes too); go to ACK.
  - mem_resp_valid is ignored in every state other than WAIT.
- ACK:
  - Granted side's ack=1 for exactly this cycle; its rdata = response register.
  - The other side's ack stays 0.
  - Always return to IDLE.
- Latency:
  - Minimum request-to-ack is 3 cycles (IDLE→REQ→WAIT→ACK) when mem_ready and mem_resp_valid arrive immediately.
  - Each cycle of memory delay adds one cycle.
- Simultaneous requests: data is served first. Fetch is re-evaluated in the IDLE cycle after data's ACK.
- Request withdrawal: if a request drops before grant, nothing is issued. The payload is latched at grant, so later input changes have no effect.
- Exactly one outstanding memory transaction; a new grant happens only from IDLE.
- rdata outputs hold the last response value between acks; bench checks them only when ack=1.
- Addresses pass through unmodified; no alignment check.
- Reset values: state=IDLE; all acks, mem_valid, mem_we = 0; mem_addr, mem_wdata, rdata, latched payload = 0.
- Reset mid-operation returns to IDLE the next edge; the in-flight transaction is abandoned. Memory shares the same reset.

Optional Feature:
MEM_ARB_PERF_EN:
- Defined: adds output ports if_wait_cnt[31:0] and d_wait_cnt[31:0].
  - Each counts cycles in which that side's stall=1.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters are absent. Functional behaviour is identical in both builds.

Decomposition:
- Shared package mem_arb_pkg:
  - State encoding (2-bit: IDLE=0, REQ=1, WAIT=2, ACK=3).
  - Grant encoding (GNT_IF=0, GNT_D=1).
  - ADDR_W/DATA_W default constants.
- One sub-module, mem_arb_wait_counter (32-bit enable-driven counter), instantiated twice, only under MEM_ARB_PERF_EN.

Test Plan:
- Fetch only: if_req, if_addr=0x10, memory responds 0xDEADBEEF with zero delay → mem_valid one cycle later with mem_addr=0x10, mem_we=0; if_ack pulses 3 cycles after request with if_rdata=0xDEADBEEF.
- Collision: if_req and d_req (load 0x200) rise the same cycle → data served first, d_ack then if_ack; never both acks in one cycle.
- Store: d_we=1, d_addr=0x40, d_wdata=0x1234 → mem_we=1 with payload stable while mem_ready is held low for 3 cycles; d_ack follows mem_resp_valid by one cycle; if_ack stays 0.
- Backpressure: mem_ready low 5 cycles, then mem_resp_valid 2 cycles later → d_stall=1 throughout; ack latency = 3+5+2 = 10 cycles.
- Reset mid-operation: reset asserted in WAIT → next cycle state IDLE, mem_valid=0, no ack; a fresh request after reset completes normally.
- With MEM_ARB_PERF_EN defined: the backpressure case yields d_wait_cnt=10 and if_wait_cnt=0.
